// File: rtl/anton_neopixel_rx_pkg.sv
// -----------------------------------------------------------------------------
// anton_neopixel_rx_pkg
// Shared defaults, FSM state encoding and a width helper for the NeoPixel
// receiver. The defaults match the timing of the anton_neopixel_raw
// transmitter at a 7 MHz tick.
// -----------------------------------------------------------------------------
package anton_neopixel_rx_pkg;

  localparam int BUFFER_END_DEFAULT    = 63;
  localparam int RESET_DELAY_DEFAULT   = 385;
  localparam int BIT_THRESHOLD_DEFAULT = 4;
  localparam int MIN_HIGH_DEFAULT      = 2;
  localparam int MAX_HIGH_DEFAULT      = 8;

  // Byte counter / frameBytes width and saturation value.
  localparam logic [12:0] FRAME_BYTES_MAX = 13'h1FFF;

  typedef enum logic [1:0] {
    ST_WAIT_SYNC = 2'd0,
    ST_IDLE      = 2'd1,
    ST_HIGH      = 2'd2,
    ST_LOW       = 2'd3
  } rx_state_e;

  // Ceiling log2, never below 1 so a one-entry buffer still gets a real port.
  function automatic int clog2_min1(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/anton_neopixel_rx_sync.sv
// -----------------------------------------------------------------------------
// anton_neopixel_rx_sync
// Brings the asynchronous NeoPixel line into the clk7mhz domain through two
// flops, keeps one more registered sample, and derives single-cycle edge
// strobes from the last two samples.
//
// Ports:
//   clk7mhz  - sampling clock
//   resetn   - synchronous reset, active low
//   i_data   - raw asynchronous line
//   o_level  - synchronized line level
//   o_rise   - one-cycle strobe on a synchronized low->high transition
//   o_fall   - one-cycle strobe on a synchronized high->low transition
// -----------------------------------------------------------------------------
module anton_neopixel_rx_sync (
  input  logic clk7mhz,
  input  logic resetn,
  input  logic i_data,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its source, regardless of statement order.
  always_ff @(posedge clk7mhz) begin
    if (!resetn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_data;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/anton_neopixel_rx.sv
// -----------------------------------------------------------------------------
// anton_neopixel_rx
// WS2812/NeoPixel receiver. Measures each high pulse in 7 MHz ticks, decodes
// it as a 0 or 1, assembles bytes MSB-first and writes them sequentially into
// an external byte buffer. A long low gap marks frame end.
//
// Ports:
//   clk7mhz      - sole clock
//   resetn       - synchronous reset, active low
//   neoDataIn    - asynchronous NeoPixel line
//   enable       - receiver enable; low forces WAIT_SYNC
//   errClear     - clears the sticky error flags
//   wrEn         - one-cycle buffer write strobe
//   wrAddr       - buffer write index
//   wrData       - decoded byte
//   frameDone    - one-cycle pulse at frame end
//   frameBytes   - complete bytes seen in the last frame (saturating)
//   synced       - high whenever the FSM is not in WAIT_SYNC
//   errGlitch    - sticky: high pulse shorter than MIN_HIGH
//   errLong      - sticky: high pulse longer than MAX_HIGH
//   errPartial   - sticky: frame ended mid-byte
//   errOverflow  - sticky: frame had more bytes than the buffer holds
// -----------------------------------------------------------------------------
module anton_neopixel_rx
  import anton_neopixel_rx_pkg::*;
#(
  parameter int  BUFFER_END    = BUFFER_END_DEFAULT,
  parameter int  RESET_DELAY   = RESET_DELAY_DEFAULT,
  parameter int  BIT_THRESHOLD = BIT_THRESHOLD_DEFAULT,
  parameter int  MIN_HIGH      = MIN_HIGH_DEFAULT,
  parameter int  MAX_HIGH      = MAX_HIGH_DEFAULT,
  localparam int BUFFER_BITS   = clog2_min1(BUFFER_END + 1)
) (
  input  logic                   clk7mhz,
  input  logic                   resetn,
  input  logic                   neoDataIn,
  input  logic                   enable,
  input  logic                   errClear,
  output logic                   wrEn,
  output logic [BUFFER_BITS-1:0] wrAddr,
  output logic [7:0]             wrData,
  output logic                   frameDone,
  output logic [12:0]            frameBytes,
  output logic                   synced,
  output logic                   errGlitch,
  output logic                   errLong,
  output logic                   errPartial,
  output logic                   errOverflow
);

  localparam int LOW_BITS = clog2_min1(RESET_DELAY + 1);
  localparam logic [LOW_BITS-1:0] LOW_LIMIT = LOW_BITS'(RESET_DELAY);

  logic w_level, w_rise, w_fall;

  anton_neopixel_rx_sync u_sync (
    .clk7mhz (clk7mhz),
    .resetn  (resetn),
    .i_data  (neoDataIn),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  rx_state_e                r_state,       w_state_nxt;
  logic [3:0]               r_high_cnt,    w_high_cnt_nxt;
  logic [LOW_BITS-1:0]      r_low_cnt,     w_low_cnt_nxt;
  logic [6:0]               r_shift,       w_shift_nxt;
  logic [2:0]               r_bit_cnt,     w_bit_cnt_nxt;
  logic [12:0]              r_byte_cnt,    w_byte_cnt_nxt;
  logic                     r_wr_en,       w_wr_en_nxt;
  logic [BUFFER_BITS-1:0]   r_wr_addr,     w_wr_addr_nxt;
  logic [7:0]               r_wr_data,     w_wr_data_nxt;
  logic                     r_frame_done,  w_frame_done_nxt;
  logic [12:0]              r_frame_bytes, w_frame_bytes_nxt;
  logic                     r_err_glitch, r_err_long, r_err_partial, r_err_overflow;
  logic                     w_set_glitch, w_set_long, w_set_partial, w_set_overflow;

  logic       w_bit;
  logic [7:0] w_byte;

  // The bit being decoded on this fall, and the byte it would complete.
  assign w_bit  = (int'(r_high_cnt) >= BIT_THRESHOLD);
  assign w_byte = {r_shift, w_bit};

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt       = r_state;
    w_high_cnt_nxt    = r_high_cnt;
    w_low_cnt_nxt     = r_low_cnt;
    w_shift_nxt       = r_shift;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_byte_cnt_nxt    = r_byte_cnt;
    w_wr_en_nxt       = 1'b0;
    w_wr_addr_nxt     = r_wr_addr;
    w_wr_data_nxt     = r_wr_data;
    w_frame_done_nxt  = 1'b0;
    w_frame_bytes_nxt = r_frame_bytes;
    w_set_glitch      = 1'b0;
    w_set_long        = 1'b0;
    w_set_partial     = 1'b0;
    w_set_overflow    = 1'b0;

    if (!enable) begin
      // Disable beats any concurrent edge: nothing is decoded or written.
      w_state_nxt    = ST_WAIT_SYNC;
      w_low_cnt_nxt  = '0;
      w_high_cnt_nxt = '0;
      w_shift_nxt    = '0;
      w_bit_cnt_nxt  = '0;
    end else begin
      unique case (r_state)
        ST_WAIT_SYNC: begin
          if (w_level)                w_low_cnt_nxt = '0;
          else if (r_low_cnt != LOW_LIMIT) w_low_cnt_nxt = r_low_cnt + LOW_BITS'(1);
          if (r_low_cnt == LOW_LIMIT) begin
            // A fresh sync starts a new frame.
            w_byte_cnt_nxt = '0;
            w_wr_addr_nxt  = '0;
            if (w_rise) begin
              w_state_nxt    = ST_HIGH;
              w_high_cnt_nxt = 4'd1;
            end else begin
              w_state_nxt    = ST_IDLE;
            end
          end
        end

        ST_IDLE: begin
          if (w_rise) begin
            w_state_nxt    = ST_HIGH;
            w_high_cnt_nxt = 4'd1;
          end
        end

        ST_HIGH: begin
          if (w_fall) begin
            if (int'(r_high_cnt) < MIN_HIGH || int'(r_high_cnt) > MAX_HIGH) begin
              w_set_glitch  = (int'(r_high_cnt) < MIN_HIGH);
              w_set_long    = (int'(r_high_cnt) > MAX_HIGH);
              w_state_nxt   = ST_WAIT_SYNC;
              w_low_cnt_nxt = '0;
              w_shift_nxt   = '0;
              w_bit_cnt_nxt = '0;
            end else begin
              w_shift_nxt   = w_byte[6:0];
              w_bit_cnt_nxt = r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (int'(r_byte_cnt) > BUFFER_END) begin
                  w_set_overflow = 1'b1;
                end else begin
                  w_wr_en_nxt   = 1'b1;
                  w_wr_addr_nxt = r_byte_cnt[BUFFER_BITS-1:0];
                  w_wr_data_nxt = w_byte;
                end
                if (r_byte_cnt != FRAME_BYTES_MAX) w_byte_cnt_nxt = r_byte_cnt + 13'd1;
              end
              w_state_nxt   = ST_LOW;
              w_low_cnt_nxt = '0;
            end
          end else if (w_level && r_high_cnt != 4'hF) begin
            w_high_cnt_nxt = r_high_cnt + 4'd1;
          end
        end

        ST_LOW: begin
          if (r_low_cnt == LOW_LIMIT) begin
            w_frame_done_nxt  = 1'b1;
            w_frame_bytes_nxt = r_byte_cnt;
            w_set_partial     = (r_bit_cnt != 3'd0);
            w_shift_nxt       = '0;
            w_bit_cnt_nxt     = '0;
            w_byte_cnt_nxt    = '0;
            w_wr_addr_nxt     = '0;
            w_state_nxt       = ST_IDLE;
            if (w_rise) begin
              w_state_nxt    = ST_HIGH;
              w_high_cnt_nxt = 4'd1;
            end
          end else if (w_rise) begin
            w_state_nxt    = ST_HIGH;
            w_high_cnt_nxt = 4'd1;
          end else if (!w_level) begin
            w_low_cnt_nxt = r_low_cnt + LOW_BITS'(1);
          end
        end

        default: w_state_nxt = ST_WAIT_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk7mhz) begin
    if (!resetn) begin
      r_state        <= ST_WAIT_SYNC;
      r_high_cnt     <= '0;
      r_low_cnt      <= '0;
      r_shift        <= '0;
      r_bit_cnt      <= '0;
      r_byte_cnt     <= '0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_wr_data      <= '0;
      r_frame_done   <= 1'b0;
      r_frame_bytes  <= '0;
      r_err_glitch   <= 1'b0;
      r_err_long     <= 1'b0;
      r_err_partial  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_high_cnt     <= w_high_cnt_nxt;
      r_low_cnt      <= w_low_cnt_nxt;
      r_shift        <= w_shift_nxt;
      r_bit_cnt      <= w_bit_cnt_nxt;
      r_byte_cnt     <= w_byte_cnt_nxt;
      r_wr_en        <= w_wr_en_nxt;
      r_wr_addr      <= w_wr_addr_nxt;
      r_wr_data      <= w_wr_data_nxt;
      r_frame_done   <= w_frame_done_nxt;
      r_frame_bytes  <= w_frame_bytes_nxt;
      // A new error in the same cycle as errClear still sets the flag.
      r_err_glitch   <= w_set_glitch   | (r_err_glitch   & ~errClear);
      r_err_long     <= w_set_long     | (r_err_long     & ~errClear);
      r_err_partial  <= w_set_partial  | (r_err_partial  & ~errClear);
      r_err_overflow <= w_set_overflow | (r_err_overflow & ~errClear);
    end
  end

  assign wrEn        = r_wr_en;
  assign wrAddr      = r_wr_addr;
  assign wrData      = r_wr_data;
  assign frameDone   = r_frame_done;
  assign frameBytes  = r_frame_bytes;
  assign synced      = (r_state != ST_WAIT_SYNC);
  assign errGlitch   = r_err_glitch;
  assign errLong     = r_err_long;
  assign errPartial  = r_err_partial;
  assign errOverflow = r_err_overflow;

endmodule

// File: tb/tb_anton_neopixel_rx.sv
// -----------------------------------------------------------------------------
// tb_anton_neopixel_rx
// Self-checking bench for anton_neopixel_rx with a 4-byte buffer. Frames are
// driven as tick-accurate line waveforms; expected writes come from the byte
// list and the buffer size.
// -----------------------------------------------------------------------------
module tb_anton_neopixel_rx;

  localparam int BE = 3;
  localparam int BB = 2;

  logic          clk7mhz = 1'b0;
  logic          resetn, neoDataIn, enable, errClear;
  logic          wrEn, frameDone, synced;
  logic [BB-1:0] wrAddr;
  logic [7:0]    wrData;
  logic [12:0]   frameBytes;
  logic          errGlitch, errLong, errPartial, errOverflow;

  anton_neopixel_rx #(.BUFFER_END(BE)) dut (
    .clk7mhz     (clk7mhz),
    .resetn      (resetn),
    .neoDataIn   (neoDataIn),
    .enable      (enable),
    .errClear    (errClear),
    .wrEn        (wrEn),
    .wrAddr      (wrAddr),
    .wrData      (wrData),
    .frameDone   (frameDone),
    .frameBytes  (frameBytes),
    .synced      (synced),
    .errGlitch   (errGlitch),
    .errLong     (errLong),
    .errPartial  (errPartial),
    .errOverflow (errOverflow)
  );

  always #5 clk7mhz = ~clk7mhz;

  int checks = 0;
  int errors = 0;

  // Observed write port activity and frame-end pulses.
  int obs_addr[$];
  int obs_data[$];
  int done_cnt = 0;

  always @(negedge clk7mhz) begin
    if (resetn === 1'b1 && wrEn === 1'b1) begin
      obs_addr.push_back(int'(wrAddr));
      obs_data.push_back(int'(wrData));
    end
    if (frameDone === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk7mhz);
    #1;
  endtask

  task automatic line(input logic level, input int n);
    neoDataIn = level;
    ticks(n);
  endtask

  task automatic send_bit(input logic b);
    if (b) begin line(1'b1, 5); line(1'b0, 4); end
    else   begin line(1'b1, 3); line(1'b0, 6); end
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_data.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_err_clear();
    errClear = 1'b1;
    ticks(1);
    errClear = 1'b0;
  endtask

  // Drive one frame of n bytes (payload MSB byte first) followed by a reset
  // gap, then compare everything the model predicts for it.
  task automatic run_frame(input string tag, input int n, input logic [47:0] payload,
                           input int exp_fb, input int exp_wr, input logic exp_ov);
    logic [7:0] b;
    int         exp_addr[$];
    int         exp_data[$];
    pulse_err_clear();
    clear_obs();
    for (int i = 0; i < n; i++) begin
      b = payload[47-8*i -: 8];
      send_byte(b);
      if (i <= BE) begin
        exp_addr.push_back(i);
        exp_data.push_back(int'(b));
      end
    end
    line(1'b0, 400);
    check({tag, " write count"}, obs_addr.size(), exp_wr);
    check({tag, " model write count"}, obs_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < obs_addr.size(); i++) begin
      check($sformatf("%s addr[%0d]", tag, i), obs_addr[i], exp_addr[i]);
      check($sformatf("%s data[%0d]", tag, i), obs_data[i], exp_data[i]);
    end
    check({tag, " frameDone pulses"}, done_cnt, 1);
    check({tag, " frameBytes"}, frameBytes, exp_fb);
    check({tag, " errOverflow"}, errOverflow, exp_ov);
    check({tag, " errPartial"}, errPartial, 1'b0);
  endtask

  typedef struct {
    string       tag;
    int          n;
    logic [47:0] payload;
    int          exp_fb;
    int          exp_wr;
    logic        exp_ov;
  } frame_vec_t;

  frame_vec_t vecs[5];

  initial begin
    int          n;
    logic [47:0] payload;
    int          hw[8];

    vecs[0] = '{tag:"three bytes",  n:3, payload:48'h123456_000000, exp_fb:3, exp_wr:3, exp_ov:1'b0};
    vecs[1] = '{tag:"one byte",     n:1, payload:48'h780000_000000, exp_fb:1, exp_wr:1, exp_ov:1'b0};
    vecs[2] = '{tag:"full buffer",  n:4, payload:48'hDEADBE_EF0000, exp_fb:4, exp_wr:4, exp_ov:1'b0};
    vecs[3] = '{tag:"overflow six", n:6, payload:48'h010203_040506, exp_fb:6, exp_wr:4, exp_ov:1'b1};
    vecs[4] = '{tag:"overflow five",n:5, payload:48'hFF00AA_5580FF, exp_fb:5, exp_wr:4, exp_ov:1'b1};

    resetn = 1'b0; neoDataIn = 1'b0; enable = 1'b1; errClear = 1'b0;
    ticks(3);
    check("reset outputs", {wrEn, wrAddr, wrData, frameDone, frameBytes, synced,
                            errGlitch, errLong, errPartial, errOverflow}, 32'd0);
    resetn = 1'b1;

    // Toggling with no sync gap: nothing decoded.
    clear_obs();
    for (int i = 0; i < 20; i++) begin line(1'b1, 3); line(1'b0, 6); end
    check("no-gap synced", synced, 1'b0);
    check("no-gap writes", obs_addr.size(), 0);
    line(1'b0, 390);
    check("gap synced", synced, 1'b1);
    send_byte(8'h3C);
    line(1'b0, 400);
    check("first byte count", obs_addr.size(), 1);
    if (obs_addr.size() > 0) begin
      check("first byte addr", obs_addr[0], 0);
      check("first byte data", obs_data[0], 32'h3C);
    end
    check("first frameBytes", frameBytes, 13'd1);

    run_frame("A5 frame", 1, 48'hA50000_000000, 1, 1, 1'b0);
    check("A5 errGlitch", errGlitch, 1'b0);
    check("A5 errLong", errLong, 1'b0);

    foreach (vecs[i]) run_frame(vecs[i].tag, vecs[i].n, vecs[i].payload,
                                vecs[i].exp_fb, vecs[i].exp_wr, vecs[i].exp_ov);

    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(1, 6));
      payload = {$urandom(), 16'($urandom())};
      run_frame($sformatf("random%0d", r), n, payload, n, (n > BE + 1) ? BE + 1 : n, n > BE + 1);
    end

    // Glitch: 1-tick high pulse.
    clear_obs();
    line(1'b1, 1); line(1'b0, 10);
    check("glitch errGlitch", errGlitch, 1'b1);
    check("glitch synced", synced, 1'b0);
    check("glitch writes", obs_addr.size(), 0);
    // Long: 12-tick high pulse after resync.
    line(1'b0, 390);
    line(1'b1, 12); line(1'b0, 10);
    check("long errLong", errLong, 1'b1);
    check("long synced", synced, 1'b0);
    pulse_err_clear();
    check("clear errGlitch", errGlitch, 1'b0);
    check("clear errLong", errLong, 1'b0);

    // Pulse-width boundaries: MIN_HIGH=2 and MAX_HIGH=8 are legal, 4 is a 1, 3 is a 0.
    hw = '{2, 8, 4, 3, 4, 2, 8, 3};
    line(1'b0, 390);
    clear_obs();
    for (int i = 0; i < 8; i++) begin line(1'b1, hw[i]); line(1'b0, 6); end
    line(1'b0, 400);
    check("boundary writes", obs_addr.size(), 1);
    if (obs_data.size() > 0) check("boundary data", obs_data[0], 32'h6A);
    check("boundary errGlitch", errGlitch, 1'b0);
    check("boundary errLong", errLong, 1'b0);

    // Twelve bits then a gap: one write, partial byte dropped.
    clear_obs();
    send_byte(8'hC3);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    line(1'b0, 400);
    check("partial writes", obs_addr.size(), 1);
    if (obs_data.size() > 0) check("partial data", obs_data[0], 32'hC3);
    check("partial errPartial", errPartial, 1'b1);
    check("partial frameBytes", frameBytes, 13'd1);

    // Reset mid-byte.
    clear_obs();
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    resetn = 1'b0;
    ticks(1);
    check("midbyte reset outputs", {wrEn, wrAddr, wrData, frameDone, frameBytes, synced,
                                    errGlitch, errLong, errPartial, errOverflow}, 32'd0);
    resetn = 1'b1;

    // Enable deassert forces WAIT_SYNC and blocks decoding.
    line(1'b0, 390);
    check("enable synced", synced, 1'b1);
    enable = 1'b0;
    ticks(1);
    check("disable synced", synced, 1'b0);
    clear_obs();
    send_byte(8'h99);
    line(1'b0, 400);
    check("disabled writes", obs_addr.size(), 0);
    enable = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_rx.md
Name: anton_neopixel_rx

Overview:
WS2812/NeoPixel receiver. It is the decoding end of the single-wire protocol that anton_neopixel_raw transmits. The block oversamples a neoData line at 7 MHz, classifies each high pulse as a 0 or 1 bit, and assembles bytes MSB-first. It then writes the bytes sequentially into a byte buffer through a simple write port. Uses: loopback verification of the transmitter, and chained-controller / pixel-capture designs.

Parameters:
BUFFER_END, `BUFFER_END_DEFAULT, last writable buffer index; capacity is BUFFER_END+1 bytes.
RESET_DELAY, `RESET_DELAY_DEFAULT (385), low ticks that mark a frame sync/reset.
BIT_THRESHOLD, 4, high-pulse length (ticks) at or above which the bit is 1.
MIN_HIGH, 2, high pulses shorter than this are glitches.
MAX_HIGH, 8, high pulses longer than this are errors.
Localparam BUFFER_BITS = `CLOG2(BUFFER_END+1).

Ports:
clk7mhz  in  1  sole clock.
resetn  in  1  synchronous reset, active low.
neoDataIn  in  1  asynchronous NeoPixel line.
enable  in  1  receiver enable.
errClear  in  1  clears the sticky error flags.
wrEn  out  1  one-cycle buffer write strobe.
wrAddr  out  BUFFER_BITS  buffer write index.
wrData  out  8  decoded byte.
frameDone  out  1  one-cycle pulse at frame end.
frameBytes  out  13  complete bytes seen in the last frame; saturates at 8191.
synced  out  1  high when not in WAIT_SYNC.
errGlitch, errLong, errPartial, errOverflow  out  1 each  sticky error flags.

Behaviour:
- Reset (resetn=0 at a clk edge): every output is 0, FSM goes to WAIT_SYNC, all counters and the shift register clear. Reset is honoured in any state, including mid-byte.
- Input conditioning: 2-FF synchronizer, then a registered previous sample. Rise and fall are single-cycle strobes, 3 cycles after the pin changes.
- High counter: 4 bits, saturates at 15. Low counter: `CLOG2(RESET_DELAY+1) bits, saturates at RESET_DELAY.
- FSM states:
  - WAIT_SYNC: the low counter runs while the line is low and clears on any high sample. When the count reaches RESET_DELAY, go to IDLE. Only this state is entered when enable=0, from any state.
  - IDLE: rise -> HIGH; high counter := 1.
  - HIGH: count while the line is high.
    - On fall with count < MIN_HIGH: set errGlitch, discard the partial byte, go to WAIT_SYNC.
    - On fall with count > MAX_HIGH: set errLong, discard the partial byte, go to WAIT_SYNC.
    - Otherwise shift in bit = (count >= BIT_THRESHOLD); count == BIT_THRESHOLD decodes as 1. Then go to LOW with the low counter cleared.
  - LOW: rise -> HIGH. If the low counter reaches RESET_DELAY, it is frame end:
    - frameDone pulses and frameBytes latches the byte count.
    - Bit count nonzero sets errPartial; the partial byte is dropped.
    - Byte count and wrAddr reset to 0; go to IDLE.
- Byte assembly: MSB first. On the 8th bit, wrEn pulses the cycle after the decoding fall, with wrAddr = byte count and wrData = the byte; then the byte count increments.
  - If byte count > BUFFER_END, wrEn is suppressed, errOverflow is set, and counting continues.
- Simultaneous events: an error set and errClear in the same cycle -> set wins. A fall and enable deassert in the same cycle -> enable wins; no write.
- A frame end within a single cycle of a write is impossible: 8th-bit write is in LOW's first cycle and RESET_DELAY > 1.

Decomposition:
- anton_common.vh gains RX defaults (BIT_THRESHOLD, MIN_HIGH, MAX_HIGH) and the RX FSM state encodings (WAIT_SYNC=0, IDLE=1, HIGH=2, LOW=3).
- CLOG2 and BUFFER_END/RESET_DELAY defaults are reused from anton_common.vh.
- Sub-module anton_neopixel_rx_sync: 2-FF synchronizer plus rise/fall strobes. The FSM, counters and write port stay in the top module.

Test Plan:
1. Hold low 390 ticks, then send 0xA5 (1=5 high/4 low, 0=3 high/6 low), then low 400 -> single wrEn, wrAddr=0, wrData=0xA5, frameDone one pulse, frameBytes=1, no errors.
2. Line toggling from reset with no 385-tick low gap -> synced=0, no wrEn. After a 390-tick low gap, the next byte 0x3C is written at address 0.
3. Bytes 0x12,0x34,0x56, reset gap, then 0x78 -> writes (0,0x12),(1,0x34),(2,0x56), frameBytes=3; then (0,0x78), frameBytes=1.
4. After sync, a 1-tick high pulse -> errGlitch=1, synced=0, no write. A 12-tick high pulse -> errLong=1. errClear=1 clears both next cycle.
5. BUFFER_END=3, 6-byte frame -> writes only to addresses 0..3, errOverflow=1, frameBytes=6.
6. 12 bits then a reset gap -> one write, errPartial=1. A separate run with resetn=0 after 4 bits of a byte -> all outputs 0 and synced=0 on the following cycle.
